register_test: RTL and testbench



---
 rtl/register_test_if.sv | 31 +++
 rtl/register_test.sv | 213 +++++++++++++++++++++
 tb/tb_register_test.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/register_test_if.sv
// ----------------------------------------------------------------------------
// register_test_if
//
// Purpose : Status bundle that the register self-test block reports on.
//
// Signals :
//   result_out  1  1 = every check so far has passed; sticky 0 after a mismatch
//   done        1  1 = vector sequence complete, result_out is final
//   fail_step   8  index of the first failing check, 8'hFF when none failed
//
// Modports:
//   master - the self-test block, which drives the status
//   slave  - whoever consumes the status (simulation top, POST logic, bench)
// ----------------------------------------------------------------------------
interface register_test_if;
    logic       result_out;
    logic       done;
    logic [7:0] fail_step;

    modport master (
        output result_out,
        output done,
        output fail_step
    );

    modport slave (
        input result_out,
        input done,
        input fail_step
    );
endinterface : register_test_if

// File: rtl/register_test.sv
// ----------------------------------------------------------------------------
// register_test
//
// Purpose : Built-in self-test for the general-purpose register primitive.
//           One WIDTH-bit register under test (RUT) is driven by a fixed
//           vector sequencer.  A sticky comparator reports the outcome on
//           the status interface.
//
//           Vector list, V = 2*WIDTH+4 entries, in order:
//             all-zeros, all-ones, walking one (bit 0 first),
//             walking zero (bit 0 first), ...0101, ...1010
//
//           Sequence after reset release:
//             CHK_RST           check 0   : RUT still cleared
//             LOAD(k) / HOLD(k) check k+1 : RUT loaded with vec[k], then held
//                                           while ~vec[k] sits on its d input
//             DONE                        : status frozen until next reset
//           done rises 1+2V cycles after reset release (73 for WIDTH=16).
//
// Parameters:
//   WIDTH  data width of the register under test, legal 4..32 (default 16)
//
// Ports:
//   clk    in   single system clock, all state on the rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    master modport of register_test_if (result_out, done, fail_step)
//
// Optional build macro:
//   REGISTER_TEST_FAULT_INJECT_EN - when defined, bit 0 of the RUT data input
//   is inverted during LOAD of the first walking-one vector (k=2).  Check 3
//   then fails (result_out=0, fail_step=3) while all later checks pass,
//   which proves the comparator can see an error.
// ----------------------------------------------------------------------------
module register_test #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    register_test_if.master bus
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter guard
    // ------------------------------------------------------------------------
    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_width_check
            $error("register_test: WIDTH must be in 4..32");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              NUM_VEC  = 2 * WIDTH + 4;
    localparam logic [7:0]      LAST_K   = 8'(NUM_VEC - 1);
    localparam logic [7:0]      NO_FAIL  = 8'hFF;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [31:0]     ALT32_01 = {16{2'b01}};
    // Bit 0 set, bit 1 clear, ... ("...0101" read MSB first)
    localparam logic [WIDTH-1:0] ALT_01  = ALT32_01[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ALT_10  = ~ALT_01;

    typedef enum logic [1:0] {
        CHK_RST,
        LOAD,
        HOLD,
        DONE
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // NOTE: declaration initialisers equal the reset values so the block also
    // runs correctly when rst_n is never pulsed (FPGA power-up / simple sims);
    // the asynchronous reset below still defines them for ASIC flows.
    state_e           state_q  = CHK_RST;
    logic [7:0]       step_q   = 8'd0;
    logic             result_q = 1'b1;
    logic             done_q   = 1'b0;
    logic [7:0]       fail_q   = NO_FAIL;
    logic [WIDTH-1:0] rut_q    = '0;

    // RUT control and comparator decode
    logic             rut_load;
    logic [WIDTH-1:0] rut_d;
    logic [WIDTH-1:0] vec_k;
    logic             mismatch;
    logic [7:0]       check_idx;

    // ------------------------------------------------------------------------
    // Vector generator: pure function of the step index, no storage needed.
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] vec_at(input logic [7:0] k);
        logic [WIDTH-1:0] v;
        int               ki;
        ki = int'(k);
        v  = '0;
        if (ki == 1) begin
            v = '1;
        end else if (ki >= 2 && ki < WIDTH + 2) begin
            v = ONE << (ki - 2);
        end else if (ki >= WIDTH + 2 && ki < 2 * WIDTH + 2) begin
            v = ~(ONE << (ki - WIDTH - 2));
        end else if (ki == 2 * WIDTH + 2) begin
            v = ALT_01;
        end else if (ki == 2 * WIDTH + 3) begin
            v = ALT_10;
        end
        return v;
    endfunction

    assign vec_k = vec_at(step_q);

    // ------------------------------------------------------------------------
    // RUT stimulus.  During HOLD the inverse of the loaded vector is presented
    // on d with load low, so a passing HOLD compare proves both load and hold.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a value before any branch so
        // no path leaves one unassigned, which would infer a latch.
        rut_load = (state_q == LOAD);
        rut_d    = (state_q == HOLD) ? ~vec_k : vec_k;
`ifdef REGISTER_TEST_FAULT_INJECT_EN
        if (state_q == LOAD && step_q == 8'd2) begin
            rut_d[0] = ~rut_d[0];
        end
`else
`endif
    end

    // ------------------------------------------------------------------------
    // Register under test: load-enabled, asynchronously cleared.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            rut_q <= '0;
        end else if (rut_load) begin
            rut_q <= rut_d;
        end
    end

    // ------------------------------------------------------------------------
    // Comparator decode: check 0 in CHK_RST, check k+1 in HOLD(k).
    // ------------------------------------------------------------------------
    always_comb begin
        mismatch  = 1'b0;
        check_idx = 8'd0;
        if (state_q == CHK_RST) begin
            mismatch  = (rut_q != '0);
            check_idx = 8'd0;
        end else if (state_q == HOLD) begin
            mismatch  = (rut_q != vec_k);
            check_idx = step_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer with registered status outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CHK_RST;
            step_q   <= 8'd0;
            result_q <= 1'b1;
            done_q   <= 1'b0;
            fail_q   <= NO_FAIL;
        end else begin
            // Sticky comparator: first failing index wins, later ones ignored.
            if (mismatch) begin
                result_q <= 1'b0;
                if (fail_q == NO_FAIL) begin
                    fail_q <= check_idx;
                end
            end

            case (state_q)
                CHK_RST: begin
                    step_q  <= 8'd0;
                    state_q <= LOAD;
                end
                LOAD: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (step_q == LAST_K) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        step_q  <= step_q + 8'd1;
                        state_q <= LOAD;
                    end
                end
                DONE: begin
                    // Frozen until the next reset.
                    state_q <= DONE;
                end
                default: begin
                    state_q <= CHK_RST;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------------
    assign bus.result_out = result_q;
    assign bus.done       = done_q;
    assign bus.fail_step  = fail_q;

endmodule : register_test

// File: tb/tb_register_test.sv
// ----------------------------------------------------------------------------
// tb_register_test
//
// Purpose : Self-checking bench for register_test.  Two instances run side
//           by side (WIDTH=16 and WIDTH=4).  When a run is started, the
//           expected outcome (latency, final result, fail index, cycle at
//           which result_out first falls) is pushed to a per-instance queue;
//           when done rises it is popped and compared.
//           Expectations follow REGISTER_TEST_FAULT_INJECT_EN when defined.
// ----------------------------------------------------------------------------
module tb_register_test;

`ifdef REGISTER_TEST_FAULT_INJECT_EN
    localparam bit FAULT = 1'b1;
`else
    localparam bit FAULT = 1'b0;
`endif

    localparam int BUDGET = 300;

    typedef struct {
        int         cycles;   // posedges from start to done visible
        logic       result;
        logic [7:0] fail;
        int         fall;     // first cycle result_out is 0, 0 = never
    } exp_t;

    logic clk     = 1'b0;
    logic rst16_n = 1'b1;
    logic rst4_n  = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb16[$];
    exp_t sb4[$];

    register_test_if bus16 ();
    register_test_if bus4 ();

    register_test #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst16_n),
        .bus   (bus16)
    );

    register_test #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .bus   (bus4)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference outcome of one complete sequence.
    function automatic exp_t model(input int width);
        exp_t e;
        e.cycles = 1 + 2 * (2 * width + 4);
        e.result = FAULT ? 1'b0 : 1'b1;
        e.fail   = FAULT ? 8'd3 : 8'hFF;
        // HOLD(2) compares on edge 7; result_out low right after it.
        e.fall   = FAULT ? 7 : 0;
        return e;
    endfunction

    function automatic logic get_done(input bit sel4);
        return sel4 ? bus4.done : bus16.done;
    endfunction

    function automatic logic get_result(input bit sel4);
        return sel4 ? bus4.result_out : bus16.result_out;
    endfunction

    function automatic logic [7:0] get_fail(input bit sel4);
        return sel4 ? bus4.fail_step : bus16.fail_step;
    endfunction

    // Counts posedges until done is seen (sampled on the falling edge).
    task automatic run_to_done(input bit sel4, output int cycles, output int fall);
        cycles = 0;
        fall   = 0;
        while (cycles < BUDGET) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (fall == 0 && get_result(sel4) == 1'b0) fall = cycles;
            if (get_done(sel4)) break;
        end
    endtask

    task automatic score(input string name, input bit sel4, input int cycles, input int fall);
        exp_t e;
        e = sel4 ? sb4.pop_front() : sb16.pop_front();
        check({name, "_latency"}, cycles, e.cycles);
        check({name, "_done"}, 32'(get_done(sel4)), 32'(1'b1));
        check({name, "_result"}, 32'(get_result(sel4)), 32'(e.result));
        check({name, "_fail_step"}, 32'(get_fail(sel4)), 32'(e.fail));
        check({name, "_result_fall"}, fall, e.fall);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_done"}, 32'(bus16.done), 32'(1'b0));
        check({name, "_result"}, 32'(bus16.result_out), 32'(1'b1));
        check({name, "_fail_step"}, 32'(bus16.fail_step), 32'(8'hFF));
    endtask

    initial begin
        int c16, f16, c4, f4, changes;
        exp_t e;

        // 1) rst_n held high from t0: both widths run from initial values.
        #1;
        check_reset_vals("t0");
        sb16.push_back(model(16));
        sb4.push_back(model(4));
        fork
            run_to_done(1'b0, c16, f16);
            run_to_done(1'b1, c4, f4);
        join
        score("poweron_w16", 1'b0, c16, f16);
        score("poweron_w4", 1'b1, c4, f4);

        // 2) Outputs frozen for 50 clocks after done.
        e       = model(16);
        changes = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus16.done !== 1'b1 || bus16.result_out !== e.result ||
                bus16.fail_step !== e.fail) changes++;
        end
        check("hold50_changes", changes, 0);
        check("hold50_fail_step", 32'(bus16.fail_step), 32'(e.fail));

        // 3) Reset low for 3 cycles, then a full run.
        @(negedge clk);
        rst16_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        repeat (3) @(negedge clk);
        check_reset_vals("rst_hold");
        rst16_n = 1'b1;
        sb16.push_back(model(16));
        run_to_done(1'b0, c16, f16);
        score("rst3_w16", 1'b0, c16, f16);

        // 4) Reset pulse at cycle 20 of a sequence, then a full rerun.
        @(negedge clk);
        rst16_n = 1'b0;
        @(negedge clk);
        rst16_n = 1'b1;
        repeat (20) @(posedge clk);
        check("mid_not_done", 32'(bus16.done), 32'(1'b0));
        #2;
        rst16_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(negedge clk);
        rst16_n = 1'b1;
        sb16.push_back(model(16));
        run_to_done(1'b0, c16, f16);
        score("mid_w16", 1'b0, c16, f16);

        // 5) WIDTH=4 after an explicit reset.
        @(negedge clk);
        rst4_n = 1'b0;
        @(negedge clk);
        check("w4_rst_done", 32'(bus4.done), 32'(1'b0));
        rst4_n = 1'b1;
        sb4.push_back(model(4));
        run_to_done(1'b1, c4, f4);
        score("rst_w4", 1'b1, c4, f4);

        check("sb16_empty", sb16.size(), 0);
        check("sb4_empty", sb4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_test
